// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet sequencer.
// Holds the FSM state enum, PID encodings, status codes and status-priority helpers.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_TOKEN,
        S_DATA,
        S_HSHK,
        S_DONE,
        S_DRAIN
    } state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_PID_ERR  = 3'd1;
    localparam logic [2:0] ST_RCV_ERR  = 3'd2;
    localparam logic [2:0] ST_LEN_ERR  = 3'd3;
    localparam logic [2:0] ST_OVERFLOW = 3'd4;

    localparam logic [6:0] MAX_PAYLOAD = 7'd64;

    // Handler state for a PID; S_DRAIN marks a PID outside the known classes.
    function automatic state_t pid_class(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SETUP: return S_TOKEN;
            PID_DATA0, PID_DATA1:       return S_DATA;
            PID_ACK, PID_NAK, PID_STALL: return S_HSHK;
            default:                    return S_DRAIN;
        endcase
    endfunction

    function automatic logic [2:0] status_rank(input logic [2:0] s);
        case (s)
            ST_RCV_ERR:  return 3'd4;
            ST_PID_ERR:  return 3'd3;
            ST_LEN_ERR:  return 3'd2;
            ST_OVERFLOW: return 3'd1;
            default:     return 3'd0;
        endcase
    endfunction

    // A new code replaces the latched one only if it ranks strictly higher.
    function automatic logic [2:0] merge_status(input logic [2:0] cur, input logic [2:0] nw);
        return (status_rank(nw) > status_rank(cur)) ? nw : cur;
    endfunction

endpackage

// File: rtl/usb_rx_crc_strip.sv
// Two-entry delay line that withholds the trailing CRC16 bytes of a data packet.
// A byte appears on dout (with dout_valid) only in the cycle a third byte is pushed behind it.
module usb_rx_crc_strip (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       flush,
    output logic [7:0] dout,
    output logic       dout_valid
);

    logic [7:0] d_new;
    logic [7:0] d_old;
    logic       v_new;
    logic       v_old;

    assign dout       = d_old;
    assign dout_valid = push && v_old;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_new <= '0;
            d_old <= '0;
            v_new <= 1'b0;
            v_old <= 1'b0;
        end else if (flush) begin
            v_new <= 1'b0;
            v_old <= 1'b0;
        end else if (push) begin
            d_old <= d_new;
            v_old <= v_new;
            d_new <= din;
            v_new <= 1'b1;
        end
    end

endmodule

// File: rtl/usb_rx_pkt_seq.sv
// USB receive packet sequencer: decodes PID, token fields and data payload,
// forwards payload to a FIFO with CRC bytes stripped, and reports a status per packet.
module usb_rx_pkt_seq
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       write_enable,
    input  logic       rcv_error,
    input  logic       eop,
    input  logic       fifo_full,
    output logic       packet_type,
    output logic [7:0] fifo_wdata,
    output logic       fifo_write,
    output logic [3:0] pid,
    output logic [6:0] token_addr,
    output logic [3:0] token_endp,
    output logic [6:0] payload_len,
    output logic       pkt_done,
    output logic [2:0] pkt_status,
    output logic       busy
);

    state_t     state;
    state_t     cls_state;
    state_t     act;
    state_t     nxt;
    state_t     rx_cls;
    logic       pid_ok;
    logic       byte_in;
    logic [1:0] cnt;
    logic [1:0] cnt_next;
    logic [2:0] new_err;
    logic       fwd;
    logic       strip_push;
    logic       strip_flush;
    logic [7:0] strip_dout;
    logic       strip_valid;

    usb_rx_crc_strip u_strip (
        .clk        (clk),
        .rst        (rst),
        .push       (strip_push),
        .din        (rx_data),
        .flush      (strip_flush),
        .dout       (strip_dout),
        .dout_valid (strip_valid)
    );

    // The PID state handles the first post-PID cycle exactly like its class state.
    always_comb begin
        act         = (state == S_PID) ? cls_state : state;
        pid_ok      = (rx_data[7:4] == ~rx_data[3:0]);
        rx_cls      = pid_ok ? pid_class(rx_data[3:0]) : S_DRAIN;
        byte_in     = write_enable && !rcv_error;
        cnt_next    = (byte_in && cnt != 2'd3) ? cnt + 2'd1 : cnt;
        strip_push  = byte_in && (act == S_DATA);
        strip_flush = (state == S_IDLE) && write_enable;
        new_err     = ST_OK;
        fwd         = 1'b0;
        case (act)
            S_TOKEN: begin
                if (byte_in && cnt == 2'd2)
                    new_err = ST_LEN_ERR;
                if (eop && cnt_next < 2'd2)
                    new_err = ST_LEN_ERR;
            end
            S_DATA: begin
                if (strip_valid) begin
                    if (payload_len == MAX_PAYLOAD)
                        new_err = ST_LEN_ERR;
                    else if (fifo_full)
                        new_err = ST_OVERFLOW;
                    else
                        fwd = 1'b1;
                end
                if (eop && cnt_next < 2'd2)
                    new_err = ST_LEN_ERR;
            end
            S_HSHK: begin
                if (byte_in)
                    new_err = ST_LEN_ERR;
            end
            default: ;
        endcase
        if (rcv_error && state != S_IDLE)
            new_err = ST_RCV_ERR;

        case (state)
            S_IDLE:  nxt = write_enable ? S_PID : S_IDLE;
            S_DONE:  nxt = S_IDLE;
            default: begin
                if (eop)
                    nxt = S_DONE;
                else if (new_err != ST_OK || act == S_DRAIN)
                    nxt = S_DRAIN;
                else
                    nxt = act;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cls_state   <= S_IDLE;
            cnt         <= '0;
            packet_type <= 1'b0;
            fifo_wdata  <= '0;
            fifo_write  <= 1'b0;
            pid         <= '0;
            token_addr  <= '0;
            token_endp  <= '0;
            payload_len <= '0;
            pkt_done    <= 1'b0;
            pkt_status  <= ST_OK;
            busy        <= 1'b0;
        end else begin
            state      <= nxt;
            busy       <= (nxt != S_IDLE);
            pkt_done   <= (nxt == S_DONE);
            fifo_write <= fwd;
            if (fwd) begin
                fifo_wdata  <= strip_dout;
                payload_len <= payload_len + 7'd1;
            end
            if (state == S_IDLE) begin
                if (write_enable) begin
                    cls_state   <= rx_cls;
                    packet_type <= (rx_cls == S_DATA);
                    pkt_status  <= (rx_cls == S_DRAIN) ? ST_PID_ERR : ST_OK;
                    if (pid_ok)
                        pid <= rx_data[3:0];
                    token_addr  <= '0;
                    token_endp  <= '0;
                    payload_len <= '0;
                    cnt         <= '0;
                end
            end else begin
                pkt_status <= merge_status(pkt_status, new_err);
                cnt        <= cnt_next;
                if (act == S_TOKEN && byte_in) begin
                    if (cnt == 2'd0) begin
                        token_addr    <= rx_data[6:0];
                        token_endp[0] <= rx_data[7];
                    end else if (cnt == 2'd1) begin
                        token_endp[3:1] <= rx_data[2:0];
                    end
                end
            end
        end
    end

endmodule

// File: doc/usb_rx_pkt_seq.md
USB_RX_PKT_SEQ -- requirements
Module: usb_rx_pkt_seq

Interface
REQ-001 The block SHALL have the port clk, in, 1, the single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, in, 1, asynchronous active-high reset.
REQ-003 The block SHALL have the port rx_data, in, 8, the received byte, valid when write_enable=1.
REQ-004 The block SHALL have the port write_enable, in, 1, a one-cycle byte strobe from the receiver.
REQ-005 The block SHALL have the port rcv_error, in, 1, a receiver error flag that is sampled every cycle.
REQ-006 The block SHALL have the port eop, in, 1, the end-of-packet indication.
REQ-007 The block SHALL have the port fifo_full, in, 1, the downstream payload FIFO full flag.
REQ-008 The block SHALL have the port packet_type, out, 1, the receiver CRC mode select: 0=CRC5/token, 1=CRC16/data.
REQ-009 The block SHALL have the ports fifo_wdata (out, 8) and fifo_write (out, 1), the payload byte and its write strobe.
REQ-010 The block SHALL have the ports pid (out, 4), token_addr (out, 7), token_endp (out, 4) and payload_len (out, 7), the decoded packet fields.
REQ-011 The block SHALL have the ports pkt_done (out, 1) and pkt_status (out, 3), a one-cycle completion pulse with its status code.
REQ-012 The block SHALL have the port busy, out, 1, which is high in every state except IDLE.

Function
REQ-013 The block SHALL implement the states IDLE, PID, TOKEN, DATA, HSHK, DONE and DRAIN.
REQ-014 IDLE SHALL go to PID on the first write_enable and SHALL process that byte as the PID in the same cycle.
REQ-015 A PID byte SHALL be valid only if rx_data[7:4] equals ~rx_data[3:0]; when valid, pid is set to rx_data[3:0].
REQ-016 PID classes SHALL be: token OUT=0001, IN=1001, SETUP=1101; data DATA0=0011, DATA1=1011; handshake ACK=0010, NAK=1010, STALL=1110. Any other value is PID_ERR.
REQ-017 packet_type SHALL be registered to 1 for the data class and to 0 otherwise, from the cycle after the PID strobe until the next PID is decoded.
REQ-018 TOKEN SHALL accept exactly 2 bytes: token_addr=byte1[6:0], token_endp={byte2[2:0],byte1[7]}. A third byte is LEN_ERR; fewer than 2 bytes at eop is LEN_ERR.
REQ-019 HSHK SHALL expect no bytes; any byte received before eop is LEN_ERR.
REQ-020 DATA SHALL strip the trailing 2 CRC bytes through a 2-entry delay line, so that a byte is forwarded to the FIFO only when a third byte arrives behind it; fifo_write and fifo_wdata SHALL be registered, 1-cycle latency from that strobe.
REQ-021 payload_len SHALL count forwarded bytes (0..64, saturating); a 65th forwarded byte is LEN_ERR, and fewer than 2 total bytes at eop is LEN_ERR.
REQ-022 If fifo_full=1 at a forward, the block SHALL suppress the write and SHALL set status to OVERFLOW.
REQ-023 rcv_error=1 in any non-IDLE state SHALL set status to RCV_ERR, which takes priority over all other codes.
REQ-024 On eop in PID, TOKEN, DATA or HSHK, the block SHALL go to DONE, and DONE SHALL pulse pkt_done for 1 cycle and then return to IDLE.
REQ-025 pkt_status SHALL take the codes 0=OK, 1=PID_ERR, 2=RCV_ERR, 3=LEN_ERR, 4=OVERFLOW, with the first error latched; the priority order is RCV_ERR > PID_ERR > LEN_ERR > OVERFLOW.
REQ-026 After any error, the block SHALL enter DRAIN, where it ignores bytes until eop and then goes to DONE.
REQ-027 When write_enable and eop occur in the same cycle, the block SHALL process the byte first and then the eop.
REQ-028 eop in IDLE SHALL be ignored.
REQ-029 pkt_status, pid and the token fields SHALL hold their values until the next PID strobe.

Reset
REQ-030 While rst=1, the state SHALL be IDLE; packet_type, fifo_write, pkt_done and busy SHALL be 0; fifo_wdata, pid, token_addr, token_endp, payload_len and pkt_status SHALL be 0; and the delay line SHALL be emptied.
REQ-031 Reset asserted mid-packet SHALL abort the packet with no pkt_done pulse; after deassertion the block SHALL wait in IDLE for the next byte.

Structure
REQ-032 The shared package usb_rx_pkg SHALL hold the state enum, the PID constants, the pkt_status codes and MAX_PAYLOAD=64.
REQ-033 The 2-byte CRC-strip delay line SHALL be a sub-module, usb_rx_crc_strip, with ports push, din, flush, dout and dout_valid.

Verification
REQ-034 The bench SHALL cover: PID 0xE1, bytes 0x85, 0x03, then eop -> pid=1, token_addr=0x05, token_endp=0x7, pkt_status=0, one pkt_done.
REQ-035 The bench SHALL cover: PID 0xC3 with 4 payload bytes and 2 CRC bytes, then eop -> exactly 4 fifo_write pulses with matching data, payload_len=4, packet_type=1, status=OK.
REQ-036 The bench SHALL cover: PID 0xC3 with 65 payload bytes and 2 CRC bytes -> 64 writes, status=LEN_ERR, DRAIN until eop.
REQ-037 The bench SHALL cover: PID 0x55 (invalid) -> status=PID_ERR; subsequent bytes are ignored; pkt_done follows eop.
REQ-038 The bench SHALL cover: data packet with fifo_full asserted on the third forwarded byte -> that write is suppressed and status=OVERFLOW; rcv_error injected in the same packet -> status=RCV_ERR.
REQ-039 The bench SHALL cover: rst asserted after 3 data bytes -> all outputs are 0 with no pkt_done; a following handshake packet, PID 0xD2 then eop, completes with status=OK.
